echo_pulse_qualifier: RTL
=========================

# echo_pulse_qualifier

Qualifies raw echo detections before they reach the sample recorder's channel selector. Sits directly upstream of the recorder's trigger-source path in the `adc_clk` domain and works on a synchronised comparator or threshold level. It suppresses transmit ring-down with a blanking window, rejects glitches shorter than a programmable width, and enforces a holdoff between echoes. It emits exactly one single-cycle `echo_pulse` per accepted echo, up to `MAX_ECHOES` per recording.

## Interface
- `CNT_W`, 13, width of the blanking counter (matches the fine timestamp width).
- `MAX_ECHOES`, 6, number of echoes accepted per recording (one per recording channel).
- `adc_clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; arms the block for a new recording.
- `stop` in 1: one-cycle pulse; disarms the block.
- `echo_in` in 1: synchronised echo level; high means the echo is present.
- `blank_len` in CNT_W: number of cycles after `start` during which `echo_in` is ignored.
- `min_width` in 8: required number of consecutive high samples; the value 0 is treated as 1.
- `holdoff` in 8: minimum number of cycles after an accepted echo before a new one can be qualified.
- `echo_pulse` out 1: one-cycle qualified echo strobe.
- `echo_count` out 3: number of echoes accepted since the last `start`.
- `armed` out 1: high in every state except IDLE.
- `overflow` out 1: sticky; an echo was seen after `MAX_ECHOES` had been accepted.
- `state_o` out 3: current state, for the CPU status register.

## Operation
- States: IDLE=0, BLANK=1, LISTEN=2, WIDTH=3, HOLDOFF=4, DONE=5.
- IDLE:
  - `start` clears `echo_count` and `overflow`, loads the blank counter with `blank_len`, then goes to BLANK.
  - If `blank_len`=0, the block goes straight to LISTEN.
- BLANK:
  - Decrements the counter; `echo_in` is ignored.
  - When the counter reaches 1, the next state is LISTEN.
- LISTEN:
  - If `echo_in` is sampled high and the effective `min_width`=1, the block fires.
  - Otherwise a high sample loads the width counter with 1 and goes to WIDTH.
- WIDTH:
  - Each high sample increments the width counter; the block fires on the edge where the count reaches `min_width`.
  - A low sample before that point returns to LISTEN without a pulse.
- Fire:
  - `echo_pulse`=1 for one cycle and `echo_count` increments.
  - If the new count equals `MAX_ECHOES`, go to DONE.
  - Otherwise load the holdoff counter with `holdoff` and go to HOLDOFF.
- HOLDOFF:
  - The counter decrements to 0.
  - The block leaves for LISTEN only when the counter is 0 and `echo_in` is sampled low, so a long echo yields exactly one pulse.
- DONE: a rising edge of `echo_in` sets `overflow`; no `echo_pulse` is generated.
- `stop` in any state → IDLE. `echo_count` and `overflow` hold their values until the next `start`.
- `start` in any armed state restarts: count and overflow are cleared and the block enters BLANK (or LISTEN if `blank_len`=0).
- If `start` and `stop` arrive in the same cycle, `stop` wins.
- Counters saturate and never wrap. `echo_count` never exceeds `MAX_ECHOES`.

## Timing
- All outputs are registered.
- Reset values: `echo_pulse`=0, `echo_count`=0, `armed`=0, `overflow`=0, `state_o`=IDLE.
- `reset_n` low mid-operation forces IDLE immediately and clears all outputs asynchronously.
- `armed` rises on the edge after `start` is sampled.
- The first `echo_in` sample considered is `blank_len`+1 edges after `start` is sampled.
- Qualification latency: if `echo_in` is first sampled high at edge k, `echo_pulse` is high during the cycle after edge k+`min_width`−1.
- Pulse spacing: two accepted echoes are at least `holdoff`+2 cycles apart.
- `echo_pulse` is never high on two consecutive cycles.
- `start`/`stop` are sampled as given; they arrive already resynchronised to `adc_clk`.

## Configuration
- `ECHO_QUAL_TIMEOUT_EN` defined:
  - Adds input `listen_window` (CNT_W) and output `timeout` (1, sticky, cleared by `start`, reset value 0).
  - A window counter loads on `start` and decrements in BLANK, LISTEN, WIDTH and HOLDOFF.
  - At expiry the block goes to DONE and sets `timeout`. A `listen_window` of 0 disables the timeout.
- `ECHO_QUAL_TIMEOUT_EN` undefined: neither port exists and listening is unbounded until `stop` or `MAX_ECHOES`.

## Structure
- Shared package `echo_qual_pkg` holds:
  - the state encoding localparams (IDLE..DONE);
  - the default `CNT_W` and `MAX_ECHOES`.
- The recorder's status decode uses the same package.
- One sub-module, `load_down_counter` (parameterised width, with load, enable, zero flag and saturation), is instantiated for the blank, holdoff and optional window counters.

## Test plan
- Blanking:
  - Stimulus: `blank_len`=20, `min_width`=3; `echo_in` high for 10 cycles starting 5 cycles after `start`.
  - Required: no `echo_pulse`; state returns to LISTEN at edge 21.
- Glitch and valid echo:
  - Stimulus: `min_width`=4; a 3-cycle high glitch, then a 6-cycle echo.
  - Required: exactly one `echo_pulse`, 3 cycles after the echo's first high sample; `echo_count`=1.
- Holdoff and long pulse:
  - Stimulus: `holdoff`=10; a 30-cycle high pulse.
  - Required: one pulse only; a second echo 12 cycles after `echo_in` falls is accepted.
- Max echoes:
  - Stimulus: 7 valid echoes.
  - Required: 6 pulses; `echo_count`=6; state DONE; `overflow`=1 after the 7th.
- Control:
  - Stimulus: `start`+`stop` in the same cycle while in LISTEN.
  - Required: state IDLE, count held.
- Reset:
  - Stimulus: `reset_n` low mid-WIDTH.
  - Required: all outputs 0 before the next clock edge.
- With `ECHO_QUAL_TIMEOUT_EN`:
  - Stimulus: `listen_window`=100, no echoes.
  - Required: `timeout`=1 and state DONE, 100 cycles after `start`.

Source files
------------

// File: rtl/echo_qual_pkg.sv
`default_nettype none
// ============================================================================
// Module      : echo_qual_pkg
// Description : Shared definitions for the echo pulse qualifier and the
//               recorder's status decode: state encoding and default sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package echo_qual_pkg;

    // Default sizing: blank counter matches the fine timestamp width, one
    // accepted echo per recording channel.
    localparam int DEFAULT_CNT_W      = 13;
    localparam int DEFAULT_MAX_ECHOES = 6;

    // State encoding as reported on state_o (CPU status register).
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BLANK   = 3'd1;
    localparam logic [2:0] ST_LISTEN  = 3'd2;
    localparam logic [2:0] ST_WIDTH   = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_BLANK   = ST_BLANK,
        S_LISTEN  = ST_LISTEN,
        S_WIDTH   = ST_WIDTH,
        S_HOLDOFF = ST_HOLDOFF,
        S_DONE    = ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/echo_pulse_qualifier_load_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : load_down_counter
// Description : Loadable down counter that saturates at zero.
//               Load has priority over enable; o_zero flags a zero count.
// Ports       : clk, rst_n (async, active-low), i_load, i_load_val, i_en,
//               o_zero
// Revision    : 1.0 - initial release
// ============================================================================
module load_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/echo_pulse_qualifier.sv
`default_nettype none
// ============================================================================
// Module      : echo_pulse_qualifier
// Description : Qualifies synchronised echo detections: blanking after start,
//               minimum-width glitch rejection, holdoff between echoes, and
//               one single-cycle echo_pulse per accepted echo (up to
//               MAX_ECHOES per recording).
// Ports       : adc_clk, reset_n (async, active-low), start, stop, echo_in,
//               blank_len, min_width, holdoff -> echo_pulse, echo_count,
//               armed, overflow, state_o
// Options     : ECHO_QUAL_TIMEOUT_EN adds listen_window / timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_pulse_qualifier
    import echo_qual_pkg::*;
#(
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int MAX_ECHOES = DEFAULT_MAX_ECHOES
) (
    input  logic             adc_clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             echo_in,
    input  logic [CNT_W-1:0] blank_len,
    input  logic [7:0]       min_width,
    input  logic [7:0]       holdoff,
    output logic             echo_pulse,
    output logic [2:0]       echo_count,
    output logic             armed,
    output logic             overflow,
    output logic [2:0]       state_o
`ifdef ECHO_QUAL_TIMEOUT_EN
    ,
    input  logic [CNT_W-1:0] listen_window,
    output logic             timeout
`endif
);

    localparam logic [2:0] c_max_echoes = 3'(MAX_ECHOES);

    state_t     r_state;
    logic       r_pulse;
    logic [2:0] r_count;
    logic       r_armed;
    logic       r_overflow;
    logic       r_echo_prev;
    logic [7:0] r_width;

    logic [7:0] w_min_width;
    logic [8:0] w_width_next;
    logic [2:0] w_count_next;
    logic       w_restart;
    logic       w_qualified;
    logic       w_fire;
    logic       w_last;
    logic       w_blank_zero;
    logic       w_hold_zero;
    logic       w_win_expire;

    assign w_min_width  = (min_width == 8'd0) ? 8'd1 : min_width;
    assign w_width_next = {1'b0, r_width} + 9'd1;
    assign w_count_next = r_count + 3'd1;
    assign w_last       = (w_count_next == c_max_echoes);
    assign w_restart    = start & ~stop;

    // Qualification on this edge: either a single-sample echo seen in LISTEN,
    // or the run in WIDTH reaching the required length. >= keeps it safe if
    // min_width is lowered mid-run.
    assign w_qualified = echo_in &
                         (((r_state == S_LISTEN) && (w_min_width == 8'd1)) ||
                          ((r_state == S_WIDTH) && (w_width_next >= {1'b0, w_min_width})));
    // start/stop/timeout take precedence over a qualification on the same edge.
    assign w_fire = w_qualified & ~start & ~stop & ~w_win_expire;

    // Blank counter is preloaded with blank_len-1 so its zero flag marks the
    // last blanked edge; blank_len=0 bypasses BLANK entirely.
    load_down_counter #(.WIDTH(CNT_W)) u_blank_cnt (
        .clk        (adc_clk),
        .rst_n      (reset_n),
        .i_load     (w_restart & (blank_len != '0)),
        .i_load_val (blank_len - CNT_W'(1)),
        .i_en       (r_state == S_BLANK),
        .o_zero     (w_blank_zero)
    );

    load_down_counter #(.WIDTH(8)) u_hold_cnt (
        .clk        (adc_clk),
        .rst_n      (reset_n),
        .i_load     (w_fire & ~w_last),
        .i_load_val (holdoff),
        .i_en       (r_state == S_HOLDOFF),
        .o_zero     (w_hold_zero)
    );

`ifdef ECHO_QUAL_TIMEOUT_EN
    logic r_timeout;
    logic r_win_active;
    logic w_win_zero;
    logic w_win_en;

    assign w_win_en = (r_state == S_BLANK) || (r_state == S_LISTEN) ||
                      (r_state == S_WIDTH) || (r_state == S_HOLDOFF);

    // Same preload-minus-one trick: zero while counting means listen_window
    // edges have elapsed since start.
    load_down_counter #(.WIDTH(CNT_W)) u_win_cnt (
        .clk        (adc_clk),
        .rst_n      (reset_n),
        .i_load     (w_restart & (listen_window != '0)),
        .i_load_val (listen_window - CNT_W'(1)),
        .i_en       (w_win_en),
        .o_zero     (w_win_zero)
    );

    assign w_win_expire = r_win_active & w_win_en & w_win_zero;

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timeout    <= 1'b0;
            r_win_active <= 1'b0;
        end else if (w_restart) begin
            r_timeout    <= 1'b0;
            r_win_active <= (listen_window != '0);
        end else if (w_win_expire && !stop) begin
            r_timeout    <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_win_expire = 1'b0;
`endif

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pulse     <= 1'b0;
            r_count     <= 3'd0;
            r_armed     <= 1'b0;
            r_overflow  <= 1'b0;
            r_echo_prev <= 1'b0;
            r_width     <= 8'd0;
        end else begin
            r_pulse     <= 1'b0;
            r_echo_prev <= echo_in;
            if (stop) begin
                r_state <= S_IDLE;
                r_armed <= 1'b0;
            end else if (start) begin
                r_count    <= 3'd0;
                r_overflow <= 1'b0;
                r_armed    <= 1'b1;
                r_state    <= (blank_len == '0) ? S_LISTEN : S_BLANK;
            end else if (w_win_expire) begin
                r_state <= S_DONE;
            end else if (w_fire) begin
                r_pulse <= 1'b1;
                r_count <= w_count_next;
                r_state <= w_last ? S_DONE : S_HOLDOFF;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_BLANK: begin
                        if (w_blank_zero) r_state <= S_LISTEN;
                    end
                    S_LISTEN: begin
                        if (echo_in) begin
                            r_width <= 8'd1;
                            r_state <= S_WIDTH;
                        end
                    end
                    S_WIDTH: begin
                        if (!echo_in) begin
                            r_state <= S_LISTEN;
                        end else if (r_width != 8'hFF) begin
                            r_width <= r_width + 8'd1;
                        end
                    end
                    S_HOLDOFF: begin
                        // Waiting for echo_in low guarantees one pulse per echo.
                        if (w_hold_zero && !echo_in) r_state <= S_LISTEN;
                    end
                    S_DONE: begin
                        if (echo_in && !r_echo_prev) r_overflow <= 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign echo_pulse = r_pulse;
    assign echo_count = r_count;
    assign armed      = r_armed;
    assign overflow   = r_overflow;
    assign state_o    = r_state;

endmodule
`default_nettype wire
